// File: rtl/saver_sd_card.sv
// saver_sd_card: copies a byte range from the core (ioctl read port) to a
// mounted SD image, one 512-byte sector at a time. Each sector is staged in a
// local buffer. A short final sector is padded with zeros before it is written.
module saver_sd_card #(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        save_req,
   input  logic [2:0]  save_sel,
   input  logic [22:0] save_size,
   input  logic [5:0]  sd_img_mounted,
   input  logic [31:0] sd_img_size,
   output logic [31:0] sd_lba,
   output logic [5:0]  sd_wr,
   input  logic        sd_busy,
   input  logic        sd_done,
   input  logic [8:0]  sd_byte_index,
   output logic [7:0]  sd_wr_data,
   output logic        ioctl_upload,
   output logic [22:0] ioctl_addr,
   output logic        ioctl_rd,
   input  logic [7:0]  ioctl_din,
   input  logic        ioctl_wait,
   output logic        saver_busy,
   output logic        save_done,
   output logic        save_err
);

   localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL_RD,
      S_FILL_WAIT,
      S_PAD,
      S_SD_REQ,
      S_SD_WAIT,
      S_FINISH
   } state_t;

   state_t      state_reg, state_next;

   // per-slot mount table
   logic [5:0]  present_reg;
   logic [22:0] img_size_reg [6];

   // transfer context
   logic [2:0]  sel_reg;
   logic [22:0] size_reg;
   logic [22:0] addr_reg;
   logic [8:0]  cnt_reg;
   logic [2:0]  lat_reg;
   logic [31:0] lba_reg;
   logic        abort_reg;
   logic        err_pulse_reg;

   // sector staging buffer
   logic [7:0]  sector_mem [512];

   // decoded helpers
   logic        sel_valid;
   logic        sel_present;
   logic [22:0] sel_img_size;
   logic        start_req;
   logic        start_bad;
   logic        start_ok;
   logic        active;
   logic        abort_hit;
   logic        rd_fire;
   logic        fill_write;
   logic        pad_write;
   logic        buf_we;
   logic [7:0]  buf_wdata;
   logic [8:0]  cnt_inc;
   logic [22:0] addr_inc;
   logic        more_data;
   logic [5:0]  slot_onehot;

   // one-hot decode of the latched slot, used for the SD write request
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_slot_dec
         assign slot_onehot[gi] = (sel_reg == 3'(gi));
      end
   endgenerate

   // request qualification, abort detection and buffer write control
   always_comb begin
      sel_valid    = (save_sel <= 3'd5);
      sel_present  = 1'b0;
      sel_img_size = '0;
      if (sel_valid) begin
         sel_present  = present_reg[save_sel];
         sel_img_size = img_size_reg[save_sel];
      end
      start_req  = (state_reg == S_IDLE) && save_req;
      start_bad  = start_req && (!sel_present || (save_size == 23'd0) ||
                                 (save_size > sel_img_size));
      start_ok   = start_req && !start_bad;
      active     = (state_reg != S_IDLE) && (state_reg != S_FINISH);
      // a remount of the slot being saved invalidates the transfer
      abort_hit  = active && sd_img_mounted[sel_reg];
      rd_fire    = (state_reg == S_FILL_RD) && !ioctl_wait && !abort_hit;
      fill_write = (state_reg == S_FILL_WAIT) && (lat_reg == RD_LAT_C) && !abort_hit;
      pad_write  = (state_reg == S_PAD) && !abort_hit;
      buf_we     = fill_write || pad_write;
      buf_wdata  = fill_write ? ioctl_din : 8'h00;
      cnt_inc    = cnt_reg + 9'd1;
      addr_inc   = addr_reg + 23'd1;
      more_data  = (addr_reg < size_reg);
   end

   // mount table: latch presence and size on each mount strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         present_reg <= '0;
         for (int i = 0; i < 6; i++) begin
            img_size_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (sd_img_mounted[i]) begin
               present_reg[i]  <= (sd_img_size != 32'd0);
               img_size_reg[i] <= sd_img_size[22:0];
            end
         end
      end
   end

   // sector buffer: core-fill write port, SD read port with one cycle latency
   always_ff @(posedge clk) begin
      if (buf_we) begin
         sector_mem[cnt_reg] <= buf_wdata;
      end
      sd_wr_data <= sector_mem[sd_byte_index];
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_ok) begin
               state_next = S_FILL_RD;
            end
         end
         S_FILL_RD: begin
            if (abort_hit) begin
               state_next = S_FINISH;
            end else if (!ioctl_wait) begin
               state_next = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (abort_hit) begin
               state_next = S_FINISH;
            end else if (lat_reg == RD_LAT_C) begin
               if (cnt_inc == 9'd0) begin
                  state_next = S_SD_REQ;
               end else if (addr_inc == size_reg) begin
                  state_next = S_PAD;
               end else begin
                  state_next = S_FILL_RD;
               end
            end
         end
         S_PAD: begin
            if (abort_hit) begin
               state_next = S_FINISH;
            end else if (cnt_inc == 9'd0) begin
               state_next = S_SD_REQ;
            end
         end
         S_SD_REQ: begin
            if (abort_hit) begin
               state_next = S_FINISH;
            end else if (sd_busy) begin
               state_next = S_SD_WAIT;
            end
         end
         S_SD_WAIT: begin
            // an abort here must still let the SD transfer complete
            if (sd_done) begin
               if (abort_reg || abort_hit || !more_data) begin
                  state_next = S_FINISH;
               end else begin
                  state_next = S_FILL_RD;
               end
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // transfer datapath: addresses, counters, sector number and abort flag
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_reg       <= '0;
         size_reg      <= '0;
         addr_reg      <= '0;
         cnt_reg       <= '0;
         lat_reg       <= '0;
         lba_reg       <= '0;
         abort_reg     <= 1'b0;
         err_pulse_reg <= 1'b0;
      end else begin
         err_pulse_reg <= start_bad;

         if (start_ok) begin
            sel_reg   <= save_sel;
            size_reg  <= save_size;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            lba_reg   <= '0;
            abort_reg <= 1'b0;
         end

         if (abort_hit) begin
            abort_reg <= 1'b1;
         end else if (state_reg == S_FINISH) begin
            abort_reg <= 1'b0;
         end

         // read latency counter: 1 in the first FILL_WAIT cycle
         if (rd_fire) begin
            lat_reg <= 3'd1;
         end else if ((state_reg == S_FILL_WAIT) && (lat_reg != RD_LAT_C)) begin
            lat_reg <= lat_reg + 3'd1;
         end

         if (fill_write) begin
            cnt_reg  <= cnt_inc;
            addr_reg <= addr_inc;
         end else if (pad_write) begin
            cnt_reg  <= cnt_inc;
         end

         if ((state_reg == S_SD_WAIT) && sd_done && !abort_reg && !abort_hit && more_data) begin
            lba_reg <= lba_reg + 32'd1;
            cnt_reg <= '0;
         end
      end
   end

   // outputs decoded from state and the registered context
   always_comb begin
      ioctl_rd     = rd_fire;
      ioctl_addr   = addr_reg;
      ioctl_upload = active;
      saver_busy   = active;
      sd_lba       = lba_reg;
      sd_wr        = '0;
      if ((state_reg == S_SD_REQ) && !abort_hit) begin
         sd_wr = slot_onehot;
      end
      save_done    = (state_reg == S_FINISH) && !abort_reg;
      save_err     = err_pulse_reg || ((state_reg == S_FINISH) && abort_reg);
   end

endmodule

// File: tb/tb_saver_sd_card.sv
// Bench for saver_sd_card: directed saves against a core read model and an
// SD sector reader that checks every written byte.
module tb_saver_sd_card;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        save_req = 1'b0;
   logic [2:0]  save_sel = '0;
   logic [22:0] save_size = '0;
   logic [5:0]  sd_img_mounted = '0;
   logic [31:0] sd_img_size = '0;
   logic [31:0] sd_lba;
   logic [5:0]  sd_wr;
   logic        sd_busy = 1'b0;
   logic        sd_done = 1'b0;
   logic [8:0]  sd_byte_index = '0;
   logic [7:0]  sd_wr_data;
   logic        ioctl_upload;
   logic [22:0] ioctl_addr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait = 1'b0;
   logic        saver_busy;
   logic        save_done;
   logic        save_err;

   int n_checks = 0;
   int n_errors = 0;

   // monitor counters
   int rd_count = 0;
   int rd_bad = 0;
   int rd_next = 0;
   int done_count = 0;
   int err_count = 0;
   int both_bad = 0;
   int wr_seen = 0;

   // core read pipeline
   logic [LAT:0] pipe_v = '0;
   int           pipe_a [LAT+1];

   saver_sd_card #(.RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .save_req(save_req), .save_sel(save_sel),
      .save_size(save_size), .sd_img_mounted(sd_img_mounted), .sd_img_size(sd_img_size),
      .sd_lba(sd_lba), .sd_wr(sd_wr), .sd_busy(sd_busy), .sd_done(sd_done),
      .sd_byte_index(sd_byte_index), .sd_wr_data(sd_wr_data), .ioctl_upload(ioctl_upload),
      .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .saver_busy(saver_busy), .save_done(save_done),
      .save_err(save_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] core_byte(input int a);
      logic [7:0] lo, hi;
      lo = a[7:0];
      hi = a[15:8];
      return lo ^ (hi * 8'd29 + 8'd7);
   endfunction

   // data is valid across the edge that ends the LAT-th cycle after ioctl_rd
   assign ioctl_din = pipe_v[LAT] ? core_byte(pipe_a[LAT]) : 8'hEE;

   // monitor and core model, sampled mid-cycle
   always @(negedge clk) begin
      pipe_v <= {pipe_v[LAT-1:0], ioctl_rd};
      pipe_a[0] <= int'(ioctl_addr);
      for (int k = 1; k <= LAT; k++) pipe_a[k] <= pipe_a[k-1];
      if (!saver_busy) rd_next <= 0;
      if (ioctl_rd) begin
         rd_count <= rd_count + 1;
         if (ioctl_wait || (int'(ioctl_addr) != rd_next)) rd_bad <= rd_bad + 1;
         rd_next <= int'(ioctl_addr) + 1;
      end
      if (save_done) done_count <= done_count + 1;
      if (save_err) err_count <= err_count + 1;
      if (save_done && save_err) both_bad <= both_bad + 1;
      if (sd_wr != 6'd0) wr_seen <= wr_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_sd_wr", 32'(sd_wr), 0);
      check_eq("rst_sd_lba", sd_lba, 0);
      check_eq("rst_upload", 32'(ioctl_upload), 0);
      check_eq("rst_rd", 32'(ioctl_rd), 0);
      check_eq("rst_addr", 32'(ioctl_addr), 0);
      check_eq("rst_busy", 32'(saver_busy), 0);
      check_eq("rst_done", 32'(save_done), 0);
      check_eq("rst_err", 32'(save_err), 0);
   endtask

   task automatic mount(input int slot, input int size);
      sd_img_mounted = 6'(1 << slot);
      sd_img_size = 32'(size);
      @(negedge clk);
      sd_img_mounted = '0;
   endtask

   // rejected request: one-cycle error pulse, no traffic
   task automatic err_req(input int sel, input int size);
      int rd0, wr0;
      rd0 = rd_count;
      wr0 = wr_seen;
      save_sel = 3'(sel);
      save_size = 23'(size);
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      check_eq("err_pulse", 32'(save_err), 1);
      check_eq("err_not_busy", 32'(saver_busy), 0);
      @(negedge clk);
      check_eq("err_one_cycle", 32'(save_err), 0);
      repeat (3) @(negedge clk);
      check_eq("err_no_rd", 32'(rd_count - rd0), 0);
      check_eq("err_no_wr", 32'(wr_seen - wr0), 0);
      $display("reject sel=%0d size=%0d", sel, size);
   endtask

   // run one save, acting as the SD side; optional remount or reset injection
   task automatic do_save(input int sel, input int size, input int busy_dly,
                          input bit remount, input int reset_at,
                          output int sectors, output int dn, output int er,
                          output int data_bad, output int hold_bad, output int rds);
      int rd0, done0, err0, budget, a;
      bit fin;
      logic [7:0] exp;
      sectors = 0; data_bad = 0; hold_bad = 0;
      rd0 = rd_count; done0 = done_count; err0 = err_count;
      save_sel = 3'(sel);
      save_size = 23'(size);
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      fin = 1'b0;
      budget = 0;
      while (!fin && budget < 20000) begin
         budget++;
         if (done_count != done0 || err_count != err0) begin
            fin = 1'b1;
         end else if (reset_at >= 0 && sectors == 1 && int'(ioctl_addr) >= reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            fin = 1'b1;
         end else if (sd_wr != 6'd0) begin
            check_eq("sd_wr_slot", 32'(sd_wr), 32'(1) << sel);
            check_eq("sd_lba_seq", sd_lba, 32'(sectors));
            for (int d = 0; d < busy_dly; d++) begin
               @(negedge clk);
               if (sd_wr != 6'(1 << sel)) hold_bad++;
            end
            sd_busy = 1'b1;
            @(negedge clk);
            check_eq("sd_wr_clear", 32'(sd_wr), 0);
            for (int i = 0; i < 512; i++) begin
               sd_byte_index = 9'(i);
               if (remount && i == 100) begin
                  sd_img_mounted = 6'(1 << sel);
                  sd_img_size = 32'd4096;
               end
               @(negedge clk);
               sd_img_mounted = '0;
               a = sectors * 512 + i;
               exp = (a < size) ? core_byte(a) : 8'h00;
               if (sd_wr_data != exp) data_bad++;
               if (sd_lba != 32'(sectors)) data_bad++;
            end
            sd_busy = 1'b0;
            sd_done = 1'b1;
            @(negedge clk);
            sd_done = 1'b0;
            sectors++;
         end else begin
            @(negedge clk);
         end
      end
      if (!fin) check_eq("save_timeout", 1, 0);
      repeat (2) @(negedge clk);
      dn = done_count - done0;
      er = err_count - err0;
      rds = rd_count - rd0;
      $display("save sel=%0d size=%0d sectors=%0d done=%0d err=%0d reads=%0d",
               sel, size, sectors, dn, er, rds);
   endtask

   int sec, dn, er, dbad, hbad, rds;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs();

      mount(2, 1024);
      mount(1, 4096);
      mount(3, 0);
      mount(5, 513);

      // rejected requests
      err_req(4, 10);
      err_req(2, 0);
      err_req(2, 1025);
      err_req(3, 1);

      // two full sectors
      do_save(2, 1024, 2, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("s1024_sectors", sec, 2);
      check_eq("s1024_done", dn, 1);
      check_eq("s1024_err", er, 0);
      check_eq("s1024_reads", rds, 1024);
      check_eq("s1024_data", dbad, 0);
      check_eq("s1024_idle_busy", 32'(saver_busy), 0);
      check_eq("s1024_idle_upload", 32'(ioctl_upload), 0);

      // partial second sector padded with zeros
      do_save(1, 700, 0, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("s700_sectors", sec, 2);
      check_eq("s700_done", dn, 1);
      check_eq("s700_reads", rds, 700);
      check_eq("s700_data", dbad, 0);

      // core stall for 20 cycles during the fill
      fork
         do_save(1, 300, 1, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
         begin
            for (int k = 0; k < 5000 && ioctl_addr < 23'd100; k++) @(negedge clk);
            @(posedge clk);
            #1 ioctl_wait = 1'b1;
            repeat (20) @(posedge clk);
            #1 ioctl_wait = 1'b0;
         end
      join
      check_eq("stall_sectors", sec, 1);
      check_eq("stall_done", dn, 1);
      check_eq("stall_reads", rds, 300);
      check_eq("stall_data", dbad, 0);

      // exactly one sector, SD slow to accept
      do_save(1, 512, 50, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("slow_sectors", sec, 1);
      check_eq("slow_hold", hbad, 0);
      check_eq("slow_done", dn, 1);
      check_eq("slow_reads", rds, 512);
      check_eq("slow_data", dbad, 0);

      // size equal to the image size, one byte into the second sector
      do_save(5, 513, 0, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("edge_sectors", sec, 2);
      check_eq("edge_done", dn, 1);
      check_eq("edge_reads", rds, 513);
      check_eq("edge_data", dbad, 0);

      // remount of the target slot during SD_WAIT
      do_save(1, 1024, 0, 1'b1, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("abort_sectors", sec, 1);
      check_eq("abort_done", dn, 0);
      check_eq("abort_err", er, 1);
      check_eq("abort_reads", rds, 512);
      check_eq("abort_busy", 32'(saver_busy), 0);

      // reset in the middle of filling the second sector
      do_save(2, 1024, 0, 1'b0, 600, sec, dn, er, dbad, hbad, rds);
      check_reset_outputs();
      check_eq("rstmid_done", dn, 0);
      check_eq("rstmid_err", er, 0);
      err_req(2, 100);
      mount(2, 1024);
      do_save(2, 1024, 0, 1'b0, -1, sec, dn, er, dbad, hbad, rds);
      check_eq("after_rst_sectors", sec, 2);
      check_eq("after_rst_done", dn, 1);
      check_eq("after_rst_reads", rds, 1024);
      check_eq("after_rst_data", dbad, 0);

      check_eq("rd_order_and_wait", rd_bad, 0);
      check_eq("done_err_exclusive", both_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
